// File: rtl/mux8_pkg.sv
// mux8_pkg: shared widths and scan state encoding for the mux8 control slice
package mux8_pkg;
   localparam int NUM_IN = 8;
   localparam int SEL_W = 3;
   localparam int CNT_W = 8;
   typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;
endpackage

// File: rtl/step_tick_gen.sv
// step_tick_gen: STEP_CYCLES down-counter, tick marks the last cycle of each step
module step_tick_gen
   import mux8_pkg::*;
#(
   parameter int STEP_CYCLES = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic en,
   output logic tick
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);
   logic [CNT_W-1:0] cnt;
   assign tick = en && (cnt == '0);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else if (clear) cnt <= LAST;
      else if (en) cnt <= tick ? LAST : cnt - 1'b1;
   end
endmodule

// File: rtl/mux8_scan_ctrl.sv
// mux8_scan_ctrl: captures a byte and steps mux8to1 select through all inputs.
// Define MUX8_SCAN_MSB_FIRST_EN to scan s from 7 down to 0.
module mux8_scan_ctrl
   import mux8_pkg::*;
#(
   parameter int STEP_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             abort,
   output logic [7:0]       A,
   output logic [SEL_W-1:0] s,
   output logic             En,
   output logic             busy,
   output logic             done
);
   scan_state_t state;
   logic tick;
   logic [SEL_W-1:0] s_next;
`ifdef MUX8_SCAN_MSB_FIRST_EN
   localparam logic [SEL_W-1:0] S_FIRST = 3'd7;
   localparam logic [SEL_W-1:0] S_LAST = 3'd0;
   assign s_next = s - 1'b1;
`else
   localparam logic [SEL_W-1:0] S_FIRST = 3'd0;
   localparam logic [SEL_W-1:0] S_LAST = 3'd7;
   assign s_next = s + 1'b1;
`endif
   // counter is held at its reload value whenever no scan is running
   step_tick_gen #(.STEP_CYCLES(STEP_CYCLES)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (state != SCAN),
      .en    (state == SCAN),
      .tick  (tick)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         A         <= '0;
         s         <= '0;
         En        <= 1'b0;
         din_ready <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               din_ready <= 1'b1;
               if (din_valid && din_ready) begin
                  A         <= din;
                  s         <= S_FIRST;
                  En        <= 1'b1;
                  busy      <= 1'b1;
                  din_ready <= 1'b0;
                  state     <= SCAN;
               end
            end
            SCAN: begin
               if (abort) begin
                  En        <= 1'b0;
                  s         <= '0;
                  busy      <= 1'b0;
                  din_ready <= 1'b1;
                  state     <= IDLE;
               end else if (tick && s == S_LAST) begin
                  En    <= 1'b0;
                  done  <= 1'b1;
                  s     <= '0;
                  state <= DONE;
               end else if (tick) begin
                  s <= s_next;
               end
            end
            DONE: begin
               done      <= 1'b0;
               busy      <= 1'b0;
               din_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// tb_mux8_scan_ctrl: two instances (STEP_CYCLES 1 and 3) checked against a timeline model
module tb_mux8_scan_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   logic [1:0][7:0] din;
   logic [1:0] dv, ab;
   logic [1:0][7:0] a_o;
   logic [1:0][2:0] s_o;
   logic [1:0] en_o, busy_o, done_o, rdy_o;
   int checks = 0;
   int errors = 0;
   int t[2];
   logic [7:0] word[2];
   logic [1:0] rdy;
   logic [7:0] yb;
   int en_cnt, done_cnt;

   always #5 clk = ~clk;

   mux8_scan_ctrl #(.STEP_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .din(din[0]), .din_valid(dv[0]), .din_ready(rdy_o[0]),
      .abort(ab[0]), .A(a_o[0]), .s(s_o[0]), .En(en_o[0]), .busy(busy_o[0]), .done(done_o[0])
   );
   mux8_scan_ctrl #(.STEP_CYCLES(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .din(din[1]), .din_valid(dv[1]), .din_ready(rdy_o[1]),
      .abort(ab[1]), .A(a_o[1]), .s(s_o[1]), .En(en_o[1]), .busy(busy_o[1]), .done(done_o[1])
   );

   function automatic int per(int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic int pos(int k);
`ifdef MUX8_SCAN_MSB_FIRST_EN
      return 7 - k;
`else
      return k;
`endif
   endfunction

   function automatic int exp_en(int i);
      return (t[i] >= 1 && t[i] <= 8 * per(i)) ? 1 : 0;
   endfunction

   function automatic int exp_s(int i);
      return exp_en(i) != 0 ? pos((t[i] - 1) / per(i)) : 0;
   endfunction

   task automatic chk(string nm, int i, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s inst%0d got %0d expected %0d at %0t", nm, i, act, exp, $time);
      end
   endtask

   // t counts cycles since the accepting edge; 0 means idle
   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            t[i] <= 0;
            word[i] <= '0;
            rdy[i] <= 1'b0;
         end else if (t[i] == 0) begin
            if (rdy[i] && dv[i]) begin
               t[i] <= 1;
               word[i] <= din[i];
               rdy[i] <= 1'b0;
            end else rdy[i] <= 1'b1;
         end else if (t[i] <= 8 * per(i)) begin
            if (ab[i]) begin
               t[i] <= 0;
               rdy[i] <= 1'b1;
            end else t[i] <= t[i] + 1;
         end else begin
            t[i] <= 0;
            rdy[i] <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk("En", i, int'(en_o[i]), exp_en(i));
         chk("s", i, int'(s_o[i]), exp_s(i));
         chk("A", i, int'(a_o[i]), int'(word[i]));
         chk("busy", i, int'(busy_o[i]), (t[i] >= 1) ? 1 : 0);
         chk("done", i, int'(done_o[i]), (t[i] == 8 * per(i) + 1) ? 1 : 0);
         chk("din_ready", i, int'(rdy_o[i]), int'(rdy[i]));
         if (en_o[i]) chk("y", i, int'(a_o[i][s_o[i]]), int'(word[i][exp_s(i)]));
      end
   end

   task automatic start(int i, logic [7:0] d);
      din[i] = d;
      dv[i] = 1'b1;
      @(posedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      din = '0;
      dv = '0;
      ab = '0;
      yb = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", 0, int'(rdy_o[0]), 1);
      // STEP_CYCLES=1 byte A5: serial stream and done/ready timing
      start(0, 8'hA5);
      en_cnt = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         dv[0] = 1'b0;
         if (k <= 8) yb[k-1] = a_o[0][s_o[0]];
         if (en_o[0]) en_cnt++;
         if (k == 9) chk("done_at_9", 0, int'(done_o[0]), 1);
         if (k == 10) chk("ready_at_10", 0, int'(rdy_o[0]), 1);
      end
      chk("y_stream_A5", 0, int'(yb), 8'hA5);
      chk("en_cycles_p1", 0, en_cnt, 8);
      // STEP_CYCLES=3 byte 3C
      start(1, 8'h3C);
      en_cnt = 0;
      done_cnt = 0;
      yb = '0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         dv[1] = 1'b0;
         if (k <= 24 && (k - 1) % 3 == 0) yb[(k-1)/3] = a_o[1][s_o[1]];
         if (en_o[1]) en_cnt++;
         if (done_o[1]) done_cnt++;
         if (k == 25) chk("done_at_25", 1, int'(done_o[1]), 1);
      end
      chk("y_stream_3C", 1, int'(yb), 8'h3C);
      chk("en_cycles_p3", 1, en_cnt, 24);
      chk("done_pulses_p3", 1, done_cnt, 1);
      // abort at the fifth step
      start(0, 8'h5A);
      done_cnt = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         dv[0] = 1'b0;
         ab[0] = (k == 5);
         if (k == 6) begin
            chk("abort_en", 0, int'(en_o[0]), 0);
            chk("abort_ready", 0, int'(rdy_o[0]), 1);
            chk("abort_A_kept", 0, int'(a_o[0]), 8'h5A);
         end
         if (done_o[0]) done_cnt++;
      end
      chk("abort_no_done", 0, done_cnt, 0);
      // abort on the final step edge
      start(1, 8'hC3);
      done_cnt = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         dv[1] = 1'b0;
         ab[1] = (k == 24);
         if (k == 25) chk("final_abort_ready", 1, int'(rdy_o[1]), 1);
         if (done_o[1]) done_cnt++;
      end
      chk("final_abort_no_done", 1, done_cnt, 0);
      // asynchronous reset in mid scan
      start(0, 8'hFF);
      dv[0] = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_A", 0, int'(a_o[0]), 0);
      chk("rst_En", 0, int'(en_o[0]), 0);
      chk("rst_busy", 0, int'(busy_o[0]), 0);
      chk("rst_ready", 0, int'(rdy_o[0]), 0);
      chk("rst_s", 0, int'(s_o[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst2", 1, int'(rdy_o[1]), 1);
      // valid held high with changing data
      repeat (400) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            din[i] = 8'($urandom);
            dv[i] = 1'b1;
            ab[i] = 1'b0;
         end
      end
      repeat (3000) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            din[i] = 8'($urandom);
            dv[i] = ($urandom_range(0, 3) != 0);
            ab[i] = ($urandom_range(0, 19) == 0);
         end
      end
      @(negedge clk);
      dv = '0;
      ab = '0;
      repeat (40) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mux8_scan_ctrl.md
Name: mux8_scan_ctrl

Overview:
- Upstream control stage for the 8-to-1 mux (mux8to1).
- Accepts one 8-bit word through a valid/ready handshake and holds it in a register that drives the mux data inputs.
- Steps the mux select through all 8 positions with enable asserted, then signals completion.
- Together with mux8to1 it forms a byte-to-serial path: the mux output y carries one bit per step.

Parameters:
- STEP_CYCLES, 1, clock cycles each select value is held; legal range 1..255.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  8  word to serialise.
- din_valid  input  1  din is valid.
- din_ready  output  1  block can accept din. Registered; high only in IDLE.
- abort  input  1  cancels an active scan.
- A  output  8  held word; drives mux A[7:0].
- s  output  3  select; drives mux s[2:0].
- En  output  1  mux enable; high only while scanning.
- busy  output  1  high in SCAN and DONE.
- done  output  1  one-cycle pulse after a complete (non-aborted) scan.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, A=0, s=0, En=0, din_ready=0, busy=0, done=0, step counter=0.
- All outputs are registered. No combinational path from input to output.
- First rising clk edge with rst_n high: din_ready goes to 1.
- States: IDLE, SCAN, DONE.
- IDLE:
  - Handshake occurs on an edge where din_valid=1 and din_ready=1.
  - At that edge: A<=din, s<=0, cnt<=0, En<=1, busy<=1, din_ready<=0, state<=SCAN.
  - din_valid with din_ready=0 is ignored. The source must hold din_valid until accepted.
- SCAN:
  - cnt increments each cycle.
  - When cnt==STEP_CYCLES-1: cnt<=0 and s<=s+1.
  - Each select value is visible for exactly STEP_CYCLES cycles.
  - A is stable for the whole scan.
- End of scan:
  - Last edge is s==7 and cnt==STEP_CYCLES-1.
  - At that edge: En<=0, done<=1, s<=0, state<=DONE. s does not wrap visibly to 0 while En=1.
  - Total time with En high = 8*STEP_CYCLES cycles.
- DONE (1 cycle): done<=0, busy<=0, din_ready<=1, state<=IDLE.
  - Minimum handshake-to-handshake spacing = 8*STEP_CYCLES+2 cycles.
- abort in SCAN:
  - Next edge: En<=0, s<=0, cnt<=0, busy<=0, din_ready<=1, state<=IDLE. No done pulse.
  - A keeps its value.
  - abort coincident with the final step edge: abort wins, no done.
- abort in IDLE or DONE: ignored.
- Reset asserted mid-scan: immediate return to reset values. No done pulse.
- While En=0 the mux output is X by design. Consumers sample y only while En=1.

Optional Feature:
- Macro: MUX8_SCAN_MSB_FIRST_EN.
- Defined: scan starts at s=7 and decrements to 0. The end condition becomes s==0 with cnt==STEP_CYCLES-1. On handshake s<=7.
- Undefined: LSB-first, s runs 0 to 7 as described above.
- Reset value of s is 0 in both builds.

Decomposition:
- Package mux8_pkg:
  - NUM_IN=8, SEL_W=3.
  - State enum scan_state_t {IDLE, SCAN, DONE}.
  - Localparam CNT_W=8.
- One natural sub-module: step_tick_gen.
  - Parameterised STEP_CYCLES down-counter with clear and enable inputs.
  - Outputs a one-cycle tick on the last cycle of each step.
  - The FSM advances s on tick.

Test Plan:
1. Reset: rst_n low mid-cycle → all outputs 0 immediately; din_ready=1 one edge after release.
2. STEP_CYCLES=1, din=8'hA5, valid on cycle 0 → En high cycles 1..8, s=0..7, mux y = 1,0,1,0,0,1,0,1; done=1 at cycle 9; din_ready=1 at cycle 10.
3. STEP_CYCLES=3, din=8'h3C → each s held 3 cycles; En high 24 cycles; done single pulse.
4. abort asserted at s=4 → En=0 and din_ready=1 next edge, no done. Repeat with abort on the final-step edge → no done.
5. din_valid held high continuously with changing din → only values present at handshake edges (every 10 cycles for STEP_CYCLES=1) are captured. A never changes during SCAN.
6. MUX8_SCAN_MSB_FIRST_EN defined, din=8'h80 → s=7..0, y=1 on the first step only, done after 8 steps.
